// File: rtl/fmul_lsh_lgs_extract_pipe.sv
// rtl/fmul_lsh_lgs_extract_pipe.sv - pipelined overflow/L/G/S extraction and round-up decision for fmul
// Optional build macro: FMUL_LGS_SINGLE_STAGE_EN removes the stage 1 registers (latency 1 instead of 2).
module fmul_lsh_lgs_extract_pipe #(
  parameter int  FRAC_W = 10,
  parameter int  LSH_W  = 4,
  localparam int SIG_W  = 2*(FRAC_W+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SIG_W-1:0] sig_mul_i,
  input  logic [LSH_W-1:0] lsh_num_i,
  input  logic [2:0]       rm_i,
  input  logic             sign_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             overflow_o,
  output logic             l_o,
  output logic             g_o,
  output logic             s_o,
  output logic             uf_l_o,
  output logic             uf_g_o,
  output logic             uf_s_o,
  output logic             round_up_o,
  output logic             uf_round_up_o,
  output logic             inexact_o
);

  // Round-up decision from an (L,G,S) triple; unused mode codes never round up.
  function automatic logic round_dec(input logic [2:0] rm, input logic sgn,
                                     input logic l, input logic g, input logic s);
    logic r;
    case (rm)
      3'd0:    r = g & (l | s);
      3'd1:    r = 1'b0;
      3'd2:    r = sgn & (g | s);
      3'd3:    r = ~sgn & (g | s);
      3'd4:    r = g;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Mask naming: hot_* are one-hot at bit position FRAC_W+k-n (p1: k=+1, p0: k=0,
  // m1: k=-1, m2: k=-2); thr_* cover every bit strictly below that position.
  // Negative positions give all-zero masks, which makes out-of-range bits read 0.
  int               n_eff;
  logic [SIG_W-1:0] ov_hot_c, hot_p1_c, hot_p0_c, hot_m1_c, hot_m2_c;
  logic [SIG_W-1:0] thr_p0_c, thr_m1_c, thr_m2_c;

  // Saturate the shift amount and build all position masks from it.
  always_comb begin
    n_eff    = (int'(lsh_num_i) > FRAC_W) ? FRAC_W : int'(lsh_num_i);
    ov_hot_c = '0;
    hot_p1_c = '0;
    hot_p0_c = '0;
    hot_m1_c = '0;
    hot_m2_c = '0;
    thr_p0_c = '0;
    thr_m1_c = '0;
    thr_m2_c = '0;
    for (int i = 0; i < SIG_W; i++) begin
      ov_hot_c[i] = (i == SIG_W - 1 - n_eff);
      hot_p1_c[i] = (i == FRAC_W + 1 - n_eff);
      hot_p0_c[i] = (i == FRAC_W - n_eff);
      hot_m1_c[i] = (i == FRAC_W - 1 - n_eff);
      hot_m2_c[i] = (i == FRAC_W - 2 - n_eff);
      thr_p0_c[i] = (i < FRAC_W - n_eff);
      thr_m1_c[i] = (i < FRAC_W - 1 - n_eff);
      thr_m2_c[i] = (i < FRAC_W - 2 - n_eff);
    end
  end

  logic             v1;
  logic             adv2;
  logic [SIG_W-1:0] s1_sig;
  logic [2:0]       s1_rm;
  logic             s1_sign;
  logic [SIG_W-1:0] s1_ov_hot, s1_hot_p1, s1_hot_p0, s1_hot_m1, s1_hot_m2;
  logic [SIG_W-1:0] s1_thr_p0, s1_thr_m1, s1_thr_m2;

  assign adv2 = ~out_valid_o | out_ready_i;

`ifdef FMUL_LGS_SINGLE_STAGE_EN
  // Masks and operands flow straight into the output stage.
  assign v1         = in_valid_i;
  assign in_ready_o = adv2;
  assign s1_sig     = sig_mul_i;
  assign s1_rm      = rm_i;
  assign s1_sign    = sign_i;
  assign s1_ov_hot  = ov_hot_c;
  assign s1_hot_p1  = hot_p1_c;
  assign s1_hot_p0  = hot_p0_c;
  assign s1_hot_m1  = hot_m1_c;
  assign s1_hot_m2  = hot_m2_c;
  assign s1_thr_p0  = thr_p0_c;
  assign s1_thr_m1  = thr_m1_c;
  assign s1_thr_m2  = thr_m2_c;
`else
  logic adv1;
  assign adv1       = ~v1 | adv2;
  assign in_ready_o = adv1;

  // Stage 1: capture masks and operands whenever the stage can advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      s1_sig    <= '0;
      s1_rm     <= '0;
      s1_sign   <= 1'b0;
      s1_ov_hot <= '0;
      s1_hot_p1 <= '0;
      s1_hot_p0 <= '0;
      s1_hot_m1 <= '0;
      s1_hot_m2 <= '0;
      s1_thr_p0 <= '0;
      s1_thr_m1 <= '0;
      s1_thr_m2 <= '0;
    end else if (adv1) begin
      v1 <= in_valid_i;
      if (in_valid_i) begin
        s1_sig    <= sig_mul_i;
        s1_rm     <= rm_i;
        s1_sign   <= sign_i;
        s1_ov_hot <= ov_hot_c;
        s1_hot_p1 <= hot_p1_c;
        s1_hot_p0 <= hot_p0_c;
        s1_hot_m1 <= hot_m1_c;
        s1_hot_m2 <= hot_m2_c;
        s1_thr_p0 <= thr_p0_c;
        s1_thr_m1 <= thr_m1_c;
        s1_thr_m2 <= thr_m2_c;
      end
    end
  end
`endif

  logic ov_c, bit_p1, bit_p0, bit_m1, bit_m2, or_p0, or_m1, or_m2;
  logic l_c, g_c, s_c, ul_c, ug_c, us_c;

  assign ov_c   = |(s1_sig & s1_ov_hot);
  assign bit_p1 = |(s1_sig & s1_hot_p1);
  assign bit_p0 = |(s1_sig & s1_hot_p0);
  assign bit_m1 = |(s1_sig & s1_hot_m1);
  assign bit_m2 = |(s1_sig & s1_hot_m2);
  assign or_p0  = |(s1_sig & s1_thr_p0);
  assign or_m1  = |(s1_sig & s1_thr_m1);
  assign or_m2  = |(s1_sig & s1_thr_m2);

  // The normal window sits one bit below the overflow window; uf sits one below that.
  assign l_c  = ov_c ? bit_p1 : bit_p0;
  assign g_c  = ov_c ? bit_p0 : bit_m1;
  assign s_c  = ov_c ? or_p0  : or_m1;
  assign ul_c = ov_c ? bit_p0 : bit_m1;
  assign ug_c = ov_c ? bit_m1 : bit_m2;
  assign us_c = ov_c ? or_m1  : or_m2;

  // Stage 2: register the selected window and the rounding decisions; hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o   <= 1'b0;
      overflow_o    <= 1'b0;
      l_o           <= 1'b0;
      g_o           <= 1'b0;
      s_o           <= 1'b0;
      uf_l_o        <= 1'b0;
      uf_g_o        <= 1'b0;
      uf_s_o        <= 1'b0;
      round_up_o    <= 1'b0;
      uf_round_up_o <= 1'b0;
      inexact_o     <= 1'b0;
    end else if (adv2) begin
      out_valid_o <= v1;
      if (v1) begin
        overflow_o    <= ov_c;
        l_o           <= l_c;
        g_o           <= g_c;
        s_o           <= s_c;
        uf_l_o        <= ul_c;
        uf_g_o        <= ug_c;
        uf_s_o        <= us_c;
        round_up_o    <= round_dec(s1_rm, s1_sign, l_c, g_c, s_c);
        uf_round_up_o <= round_dec(s1_rm, s1_sign, ul_c, ug_c, us_c);
        inexact_o     <= g_c | s_c;
      end
    end
  end

endmodule
